cobs_stream_decoder: RTL and testbench



---
 rtl/cobs_pkg.sv | 24 ++
 rtl/cobs_stream_decoder_if.sv | 27 ++
 rtl/cobs_fifo.sv | 55 +++++
 rtl/cobs_stream_decoder.sv | 134 +++++++++++++
 tb/tb_cobs_stream_decoder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cobs_pkg.sv
// COBS decoder shared types and constants.
// Entries carry a marker bit above the data byte.
package cobs_pkg;

  typedef enum logic {
    ST_CODE,
    ST_DATA
  } state_e;

  localparam logic [7:0] COBS_DELIM   = 8'h00;
  localparam logic [7:0] COBS_MAXCODE = 8'hFF;

  localparam int ENTRY_W = 9;
  localparam int MARKER  = 8;

  typedef logic [ENTRY_W-1:0] entry_t;

  localparam entry_t MARK_ENTRY = 9'h100;

  function automatic entry_t data_entry(logic [7:0] b);
    return {1'b0, b};
  endfunction

endpackage

// File: rtl/cobs_stream_decoder_if.sv
// Byte-in / strobe-out bundle of the COBS decoder.
// master drives raw bytes and busy; slave is the decoder.
interface cobs_stream_decoder_if #(
  parameter int FIFO_AW = 4
);
  logic             in_flag;
  logic [7:0]       in_data;
  logic             busy;
  logic             o_flag;
  logic [7:0]       o_data;
  logic             o_sof;
  logic             o_err;
  logic             o_overrun;
  logic [FIFO_AW:0] o_level;

  modport master (
    output in_flag, in_data, busy,
    input  o_flag, o_data, o_sof,
    input  o_err, o_overrun, o_level
  );

  modport slave (
    input  in_flag, in_data, busy,
    output o_flag, o_data, o_sof,
    output o_err, o_overrun, o_level
  );
endinterface

// File: rtl/cobs_fifo.sv
// Small synchronous FIFO of decoder entries.
// Pointers carry one extra wrap bit to tell full from empty.
module cobs_fifo
  import cobs_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  entry_t       din,
  input  logic         pop,
  output entry_t       dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  entry_t      mem_q [2**AW];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;
  assign dout  = mem_q[rd_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cobs_stream_decoder.sv
// COBS de-framing front end of the UART command parser.
// Decoded bytes and frame markers are queued, then paced out.
module cobs_stream_decoder
  import cobs_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  cobs_stream_decoder_if.slave   bus
);

  state_e     state_q, state_d;
  logic       first_q, first_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] prev_q, prev_d;

  logic       push;
  entry_t     push_entry;
  logic       err_d;

  logic       pop_q, pop_d;
  logic       flag_q, flag_d;
  logic       sof_q, sof_d;
  logic       err_q;
  logic       ovr_q, ovr_d;
  logic [7:0] data_q, data_d;

  entry_t     rd_entry;
  logic       full;
  logic       empty;

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    push       = 1'b0;
    push_entry = '0;
    err_d      = 1'b0;
    if (bus.in_flag) begin
      unique case (state_q)
        ST_CODE: begin
          if (bus.in_data == COBS_DELIM) begin
            push       = 1'b1;
            push_entry = MARK_ENTRY;
            first_d    = 1'b1;
          end else begin
            // Zero implied by the previous group, unless it was a max-length one
            if (!first_q && prev_q != COBS_MAXCODE) begin
              push       = 1'b1;
              push_entry = data_entry(COBS_DELIM);
            end
            cnt_d   = bus.in_data - 8'd1;
            prev_d  = bus.in_data;
            first_d = 1'b0;
            state_d = (bus.in_data != 8'd1) ? ST_DATA : ST_CODE;
          end
        end
        ST_DATA: begin
          if (bus.in_data == COBS_DELIM) begin
            err_d      = 1'b1;
            push       = 1'b1;
            push_entry = MARK_ENTRY;
            first_d    = 1'b1;
            state_d    = ST_CODE;
          end else begin
            push       = 1'b1;
            push_entry = data_entry(bus.in_data);
            cnt_d      = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = ST_CODE;
          end
        end
        default: ;
      endcase
    end
  end

  cobs_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop_d),
    .dout  (rd_entry),
    .full  (full),
    .empty (empty),
    .level (bus.o_level)
  );

  // Skipping the cycle after a pop hides the consumer's busy latency
  always_comb begin
    pop_d  = !empty && !bus.busy && !pop_q;
    flag_d = pop_d && !rd_entry[MARKER];
    sof_d  = pop_d && rd_entry[MARKER];
    data_d = flag_d ? rd_entry[7:0] : data_q;
    ovr_d  = push && full;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CODE;
      first_q <= 1'b1;
      cnt_q   <= '0;
      prev_q  <= '0;
      pop_q   <= 1'b0;
      flag_q  <= 1'b0;
      sof_q   <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      pop_q   <= pop_d;
      flag_q  <= flag_d;
      sof_q   <= sof_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      data_q  <= data_d;
    end
  end

  assign bus.o_flag    = flag_q;
  assign bus.o_data    = data_q;
  assign bus.o_sof     = sof_q;
  assign bus.o_err     = err_q;
  assign bus.o_overrun = ovr_q;

endmodule

// File: tb/tb_cobs_stream_decoder.sv
// Bench for cobs_stream_decoder: COBS reference model plus
// queue-based output schedule, checked every cycle.
module tb_cobs_stream_decoder;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int MARK  = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cobs_stream_decoder_if #(.FIFO_AW(AW)) bus ();

  cobs_stream_decoder #(.FIFO_AW(AW)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic cmp(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  logic force_busy = 1'b0;
  logic cons_en    = 1'b0;
  logic rnd_en     = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.busy <= 1'b0;
    else bus.busy <= force_busy | (cons_en & bus.o_flag) |
                     (rnd_en & ($urandom_range(0, 2) == 0));
  end

  // Reference: COBS meaning of the byte stream, queue of entries,
  // output schedule from the pop rule
  int   mq[$];
  int   remain;
  bit   pend;
  bit   pop_prev;
  logic exp_flag, exp_sof, exp_err, exp_ovr;
  logic [7:0] exp_data;

  always @(posedge clk or negedge rst_n) begin
    bit pop;
    bit has_ev;
    bit err;
    int ev;
    int b;
    int front;
    if (!rst_n) begin
      mq.delete();
      remain = 0; pend = 0; pop_prev = 0;
      exp_flag = 0; exp_sof = 0; exp_err = 0; exp_ovr = 0;
      exp_data = '0;
    end else begin
      pop = (mq.size() > 0) && !bus.busy && !pop_prev;
      has_ev = 0; err = 0; ev = 0;
      if (bus.in_flag) begin
        b = int'(bus.in_data);
        if (b == 0) begin
          err = (remain > 0);
          has_ev = 1; ev = MARK;
          remain = 0; pend = 0;
        end else if (remain == 0) begin
          if (pend) begin has_ev = 1; ev = 0; end
          remain = b - 1;
          pend = (b != 255);
        end else begin
          has_ev = 1; ev = b;
          remain--;
        end
      end
      exp_err = err;
      exp_ovr = has_ev && (mq.size() >= DEPTH);
      exp_flag = 0; exp_sof = 0;
      if (pop) begin
        front = mq.pop_front();
        if (front == MARK) exp_sof = 1;
        else begin exp_flag = 1; exp_data = 8'(front); end
      end
      if (has_ev && !exp_ovr) mq.push_back(ev);
      pop_prev = pop;
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      cmp("o_flag", bus.o_flag, exp_flag);
      cmp("o_sof", bus.o_sof, exp_sof);
      cmp("o_err", bus.o_err, exp_err);
      cmp("o_overrun", bus.o_overrun, exp_ovr);
      cmp("o_data", bus.o_data, exp_data);
      cmp("o_level", bus.o_level, mq.size());
    end
  end

  // Event log of delivered output for the literal checks
  int log_q[$];
  int cyc     = 0;
  int last_ev = -1;
  int ovr_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) last_ev = -1;
    else begin
      cyc++;
      if (bus.o_flag || bus.o_sof) begin
        if (last_ev >= 0) cmp("pop_spacing", int'(cyc - last_ev >= 2), 1);
        last_ev = cyc;
      end
      if (bus.o_flag) log_q.push_back(int'(bus.o_data));
      if (bus.o_sof) log_q.push_back(MARK);
      if (bus.o_overrun) ovr_cnt++;
      if (bus.o_err) err_cnt++;
    end
  end

  task automatic send(input int b, input int gap);
    @(negedge clk);
    bus.in_flag = 1'b1;
    bus.in_data = 8'(b);
    @(negedge clk);
    bus.in_flag = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 2000; i++) begin
      if (mq.size() == 0) break;
      @(negedge clk);
    end
    if (mq.size() != 0) cmp("drain_timeout", mq.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_log(input string name, input int exp[$]);
    int k;
    cmp({name, "_len"}, log_q.size(), exp.size());
    k = exp.size() - 1;
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      if (log_q[i] != exp[i]) begin k = i; break; end
    if (k >= 0 && k < log_q.size()) cmp(name, log_q[k], exp[k]);
  endtask

  task automatic chk_zero(input string tag);
    cmp({tag, "_flag"}, bus.o_flag, 0);
    cmp({tag, "_data"}, bus.o_data, 0);
    cmp({tag, "_sof"}, bus.o_sof, 0);
    cmp({tag, "_err"}, bus.o_err, 0);
    cmp({tag, "_ovr"}, bus.o_overrun, 0);
    cmp({tag, "_level"}, bus.o_level, 0);
  endtask

  initial begin
    int exp[$];
    int b;
    bus.in_flag = 1'b0;
    bus.in_data = '0;
    #2 rst_n = 1'b0;
    #10 chk_zero("rst");
    #11 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1;

    // Plain frame with an implied zero between groups
    log_q.delete(); err_cnt = 0;
    foreach (exp[i]) exp.delete();
    exp = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
    foreach (exp[i]) send(exp[i], 0);
    wait_idle();
    check_log("frame1", '{MARK, 'h11, 'h22, 0, 'h33, MARK});
    cmp("frame1_err", err_cnt, 0);

    // Max-length group: no implied zero after code FF
    log_q.delete();
    send('hFF, 1);
    for (int i = 1; i <= 254; i++) send(i, 1);
    send('h02, 1); send('hAA, 1); send('h00, 1);
    wait_idle();
    exp.delete();
    for (int i = 1; i <= 254; i++) exp.push_back(i);
    exp.push_back('hAA); exp.push_back(MARK);
    check_log("ff_group", exp);

    // Delimiter inside a group aborts, then a clean frame
    log_q.delete(); err_cnt = 0;
    send('h05, 0); send('h11, 0); send('h22, 0); send('h00, 0);
    send('h02, 0); send('h77, 0); send('h00, 0);
    wait_idle();
    check_log("abort", '{'h11, 'h22, MARK, 'h77, MARK});
    cmp("abort_err", err_cnt, 1);

    // Overflow with the consumer stalled
    force_busy = 1'b1;
    repeat (3) @(negedge clk);
    log_q.delete(); ovr_cnt = 0;
    send('h15, 0);
    for (int i = 0; i < 20; i++) send('h31 + i, 0);
    repeat (3) @(negedge clk);
    cmp("sat_level", bus.o_level, 16);
    cmp("sat_overruns", ovr_cnt, 4);
    force_busy = 1'b0;
    wait_idle();
    exp.delete();
    for (int i = 0; i < 16; i++) exp.push_back('h31 + i);
    check_log("drain16", exp);
    send('h00, 0);
    wait_idle();

    // Random streams under consumer-style and random backpressure
    cons_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) b = 0;
      else if ($urandom_range(0, 1) == 0) b = $urandom_range(1, 6);
      else b = $urandom_range(1, 255);
      send(b, $urandom_range(0, 3));
    end
    send(0, 0);
    wait_idle();
    cons_en = 1'b0;
    rnd_en  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) b = 0;
      else b = $urandom_range(1, 9);
      send(b, $urandom_range(0, 2));
    end
    send(0, 0);
    wait_idle();
    rnd_en = 1'b0;

    // Asynchronous reset in the middle of a group
    send('h03, 0); send('h11, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("arst");
    #14 rst_n = 1'b1;
    log_q.delete();
    repeat (3) @(negedge clk);
    cmp("arst_quiet", log_q.size(), 0);
    send('h02, 0); send('h55, 0); send('h00, 0);
    wait_idle();
    check_log("post_rst", '{'h55, MARK});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
